// File: rtl/led_display_package.sv
// -----------------------------------------------------------------------------
// led_display_package
// Shared types and constants for the LED display pipeline.
//   rgb_row_t / GL_RGB_ROW_W  : one scan row of RGB data (pattern gen -> PHY)
//   GL_NUM_ROW_ADDR / _W      : panel scan-row address space (16 rows, 4 bits)
//   row_seq_state_t           : states of led_display_row_sequencer
//   gl_max_u()                : constant-foldable max helper for sizing
// -----------------------------------------------------------------------------
package led_display_package;

    localparam int unsigned GL_RGB_ROW_W    = 24;
    typedef logic [GL_RGB_ROW_W-1:0] rgb_row_t;

    localparam int unsigned GL_NUM_ROW_ADDR = 16;
    localparam int unsigned GL_ROW_ADDR_W   = 4;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StShift,
        StWaitDone,
        StWaitDwell,
        StBlank,
        StLatch,
        StUnblank
    } row_seq_state_t;

    function automatic int unsigned gl_max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_display_row_timer.sv
// -----------------------------------------------------------------------------
// led_display_row_timer
// Loadable down-counter that saturates at zero, with a zero flag. Shared by the
// row sequencer's dwell and blank phases.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset (count resets to 0)
//   i_load         : load i_load_value this cycle (overrides the decrement)
//   i_load_value   : value to load
//   o_zero         : counter currently holds zero
// -----------------------------------------------------------------------------
module led_display_row_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_value,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/led_display_row_sequencer.sv
// -----------------------------------------------------------------------------
// led_display_row_sequencer
// Pulls one row per scan line from the pattern generator, starts the PHY shift,
// then blanks, latches, updates the panel row address and holds the row lit for
// at least ROW_DWELL_CYCLES. Flags frame end (row 15 latched).
// Optional feature: define LED_DISPLAY_ROW_SEQ_ADDR_CHECK_EN to enable the
// row-address sequence checker (addr_error_out); otherwise it is tied to 0.
// Ports:
//   clk_in, n_reset_in        : clock, asynchronous active-low reset
//   enable_in                 : run request
//   row_in/row_valid_in/row_ready_out/row_address_in : row input handshake
//   phy_row_out, phy_start_out, phy_done_in          : PHY shift interface
//   latch_out, n_oe_out, addr_out                    : panel control
//   frame_done_out, addr_error_out                   : status pulses
// All outputs are registered.
// -----------------------------------------------------------------------------
module led_display_row_sequencer
    import led_display_package::*;
#(
    parameter int unsigned SYS_CLK_FREQ     = 100_000_000,
    parameter int unsigned ROW_DWELL_CYCLES = 2000,
    parameter int unsigned BLANK_CYCLES     = 16
) (
    input  logic                     clk_in,
    input  logic                     n_reset_in,
    input  logic                     enable_in,
    input  logic [GL_RGB_ROW_W-1:0]  row_in,
    input  logic                     row_valid_in,
    output logic                     row_ready_out,
    input  logic [GL_ROW_ADDR_W-1:0] row_address_in,
    output logic [GL_RGB_ROW_W-1:0]  phy_row_out,
    output logic                     phy_start_out,
    input  logic                     phy_done_in,
    output logic                     latch_out,
    output logic                     n_oe_out,
    output logic [GL_ROW_ADDR_W-1:0] addr_out,
    output logic                     frame_done_out,
    output logic                     addr_error_out
);

    localparam int unsigned CNT_MAX = gl_max_u(ROW_DWELL_CYCLES, BLANK_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    if (ROW_DWELL_CYCLES < 1 || BLANK_CYCLES < 1 || SYS_CLK_FREQ == 0) begin : g_param_check
        $error("led_display_row_sequencer: invalid parameter value");
    end

    row_seq_state_t           r_state;
    row_seq_state_t           w_state_next;
    logic                     w_accept;
    logic                     w_tmr_load;
    logic [CNT_W-1:0]         w_tmr_value;
    logic                     w_tmr_zero;

    logic                     r_row_ready;
    rgb_row_t                 r_phy_row;
    logic [GL_ROW_ADDR_W-1:0] r_pending_addr;
    logic                     r_phy_start;
    logic                     r_latch;
    logic                     r_n_oe;
    logic [GL_ROW_ADDR_W-1:0] r_addr;
    logic                     r_frame_done;

    // r_row_ready is high exactly in FETCH, so this is the handshake.
    assign w_accept = (r_state == StFetch) && enable_in && row_valid_in && r_row_ready;

    led_display_row_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk        (clk_in),
        .i_rst_n      (n_reset_in),
        .i_load       (w_tmr_load),
        .i_load_value (w_tmr_value),
        .o_zero       (w_tmr_zero)
    );

    always_comb begin
        w_state_next = r_state;
        w_tmr_load   = 1'b0;
        w_tmr_value  = '0;
        case (r_state)
            StIdle: begin
                if (enable_in) begin
                    w_state_next = StFetch;
                end
            end
            StFetch: begin
                if (!enable_in) begin
                    w_state_next = StIdle;
                end else if (w_accept) begin
                    w_state_next = StShift;
                end
            end
            StShift: begin
                w_state_next = StWaitDone;
            end
            StWaitDone: begin
                if (phy_done_in) begin
                    w_state_next = StWaitDwell;
                end
            end
            StWaitDwell: begin
                if (w_tmr_zero) begin
                    // BLANK exits on the zero flag, so loading N-1 gives N BLANK cycles.
                    w_tmr_load   = 1'b1;
                    w_tmr_value  = CNT_W'(BLANK_CYCLES - 1);
                    w_state_next = StBlank;
                end
            end
            StBlank: begin
                if (w_tmr_zero) begin
                    w_state_next = StLatch;
                end
            end
            StLatch: begin
                w_state_next = StUnblank;
            end
            StUnblank: begin
                w_tmr_load   = 1'b1;
                w_tmr_value  = CNT_W'(ROW_DWELL_CYCLES);
                w_state_next = StFetch;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            r_state        <= StIdle;
            r_row_ready    <= 1'b0;
            r_phy_row      <= '0;
            r_pending_addr <= '0;
            r_phy_start    <= 1'b0;
            r_latch        <= 1'b0;
            r_n_oe         <= 1'b1;
            r_addr         <= '0;
            r_frame_done   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_row_ready  <= (w_state_next == StFetch);
            r_phy_start  <= (w_state_next == StShift);
            r_latch      <= (w_state_next == StLatch);
            r_frame_done <= (w_state_next == StLatch) &&
                            (r_pending_addr == GL_ROW_ADDR_W'(GL_NUM_ROW_ADDR - 1));
            if (w_accept) begin
                r_phy_row      <= row_in;
                r_pending_addr <= row_address_in;
            end
            if (w_state_next == StLatch) begin
                r_addr <= r_pending_addr;
            end
            // Panel stays dark from IDLE until the first row is latched; once lit it
            // stays lit through the next fetch/shift/dwell.
            case (w_state_next)
                StIdle, StBlank, StLatch: r_n_oe <= 1'b1;
                StUnblank:                r_n_oe <= 1'b0;
                default:                  r_n_oe <= r_n_oe;
            endcase
        end
    end

`ifdef LED_DISPLAY_ROW_SEQ_ADDR_CHECK_EN
    logic [GL_ROW_ADDR_W-1:0] r_exp_addr;
    logic                     r_addr_error;

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            r_exp_addr   <= '0;
            r_addr_error <= 1'b0;
        end else begin
            r_addr_error <= w_accept && (row_address_in != r_exp_addr);
            // Match: expected+1 == address+1; mismatch: resync to address+1.
            if (w_accept) begin
                r_exp_addr <= row_address_in + 1'b1;
            end
        end
    end

    assign addr_error_out = r_addr_error;
`else
    assign addr_error_out = 1'b0;
`endif

    assign row_ready_out  = r_row_ready;
    assign phy_row_out    = r_phy_row;
    assign phy_start_out  = r_phy_start;
    assign latch_out      = r_latch;
    assign n_oe_out       = r_n_oe;
    assign addr_out       = r_addr;
    assign frame_done_out = r_frame_done;

endmodule

// File: tb/tb_led_display_row_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_display_row_sequencer
// Scoreboard bench: each accepted row pushes its expected PHY data, latch
// address/frame flag and address-error flag; a monitor pops and compares when
// the DUT pulses phy_start_out, latch_out, or one cycle after an accept.
// Also measures blank/lit window lengths on n_oe_out.
// -----------------------------------------------------------------------------
module tb_led_display_row_sequencer;
    import led_display_package::*;

    localparam int unsigned DWELL = 200;
    localparam int unsigned BLANK = 16;
`ifdef LED_DISPLAY_ROW_SEQ_ADDR_CHECK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       enable = 1'b0;
    rgb_row_t   row_data = '0;
    logic       row_valid = 1'b0;
    logic [3:0] row_addr = '0;
    logic       phy_done = 1'b0;

    logic       row_ready_out;
    rgb_row_t   phy_row_out;
    logic       phy_start_out;
    logic       latch_out;
    logic       n_oe_out;
    logic [3:0] addr_out;
    logic       frame_done_out;
    logic       addr_error_out;

    led_display_row_sequencer #(
        .SYS_CLK_FREQ     (100_000_000),
        .ROW_DWELL_CYCLES (DWELL),
        .BLANK_CYCLES     (BLANK)
    ) dut (
        .clk_in         (clk),
        .n_reset_in     (n_reset),
        .enable_in      (enable),
        .row_in         (row_data),
        .row_valid_in   (row_valid),
        .row_ready_out  (row_ready_out),
        .row_address_in (row_addr),
        .phy_row_out    (phy_row_out),
        .phy_start_out  (phy_start_out),
        .phy_done_in    (phy_done),
        .latch_out      (latch_out),
        .n_oe_out       (n_oe_out),
        .addr_out       (addr_out),
        .frame_done_out (frame_done_out),
        .addr_error_out (addr_error_out)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    rgb_row_t   exp_row_q[$];
    logic [4:0] exp_latch_q[$];
    logic       exp_err_q[$];

    int  phy_delay = 50;
    bit  long_mode = 1'b0;
    bit  toggle_mode = 1'b0;
    int  latch_cnt = 0;
    int  frame_cnt = 0;
    int  start_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // PHY model: done pulse in the cycle phy_delay cycles after the start cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (n_reset && phy_start_out) begin
                repeat (phy_delay) @(posedge clk);
                #1 phy_done = 1'b1;
                @(posedge clk);
                #1 phy_done = 1'b0;
            end
        end
    end

    // Monitor
    bit          prev_start = 1'b0;
    bit          prev_noe = 1'b1;
    bit          acc_prev = 1'b0;
    bit          done_in_lit = 1'b0;
    bit          ready_in_high = 1'b1;
    int          lit_len = 0;
    int          high_len = 0;
    int unsigned done_cyc = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!n_reset) begin
                prev_start = 1'b0; prev_noe = 1'b1; acc_prev = 1'b0;
                lit_len = 0; high_len = 0; done_in_lit = 1'b0; ready_in_high = 1'b1;
            end else begin
                if (n_oe_out) begin
                    if (!prev_noe) begin
                        if (done_in_lit) begin
                            if (long_mode) begin
                                check("lit_len", lit_len, phy_delay + 4);
                                check("done_to_blank", cyc - done_cyc, 2);
                            end else begin
                                check("lit_min", lit_len >= DWELL, 1);
                            end
                        end
                        high_len = 0;
                        ready_in_high = 1'b0;
                    end
                    high_len++;
                    if (row_ready_out) ready_in_high = 1'b1;
                end else begin
                    if (prev_noe) begin
                        lit_len = 0;
                        done_in_lit = 1'b0;
                    end
                    lit_len++;
                end
                if (phy_done) begin
                    done_cyc = cyc;
                    if (!n_oe_out) done_in_lit = 1'b1;
                end

                if (phy_start_out) begin
                    start_cnt++;
                    check("phy_start_single", {63'b0, prev_start}, 0);
                    if (exp_row_q.size() == 0) fail_now("phy_start_unexpected");
                    else check("phy_row", phy_row_out, exp_row_q.pop_front());
                end

                if (latch_out) begin
                    logic [4:0] e;
                    latch_cnt++;
                    if (exp_latch_q.size() == 0) begin
                        fail_now("latch_unexpected");
                    end else begin
                        e = exp_latch_q.pop_front();
                        check("addr_out", addr_out, e[3:0]);
                        check("frame_done", frame_done_out, e[4]);
                    end
                    if (!ready_in_high) check("blank_len", high_len, BLANK + 1);
                end
                if (frame_done_out) begin
                    frame_cnt++;
                    check("frame_outside_latch", latch_out, 1);
                end

                if (acc_prev) begin
                    if (exp_err_q.size() == 0) fail_now("addr_error_unexpected_accept");
                    else check("addr_error", addr_error_out, exp_err_q.pop_front());
                end else if (addr_error_out) begin
                    check("addr_error_spurious", addr_error_out, 0);
                end

                acc_prev = row_valid && row_ready_out && enable;
                prev_start = phy_start_out;
                prev_noe = n_oe_out;
            end
        end
    end

    task automatic send_row(input rgb_row_t d, input logic [3:0] a, input logic e);
        int n = 0;
        bit done = 1'b0;
        row_data = d;
        row_addr = a;
        while (!done) begin
            row_valid = toggle_mode ? ~row_valid : 1'b1;
            @(negedge clk);
            if (row_valid && row_ready_out && enable) begin
                exp_row_q.push_back(d);
                exp_latch_q.push_back({(a == 4'd15), a});
                exp_err_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 5000) begin
                fail_now("send_timeout");
                done = 1'b1;
            end
        end
    endtask

    task automatic wait_latches(input int target);
        int n = 0;
        while (latch_cnt < target && n < 20000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("latch_count", latch_cnt, target);
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        enable = 1'b0;
        row_valid = 1'b0;
        toggle_mode = 1'b0;
        long_mode = 1'b0;
        phy_delay = 50;
        exp_row_q.delete();
        exp_latch_q.delete();
        exp_err_q.delete();
        repeat (3) @(posedge clk);
        #1;
        latch_cnt = 0;
        frame_cnt = 0;
        start_cnt = 0;
        n_reset = 1'b1;
    endtask

    task automatic check_reset_values(input string name);
        check(name, {phy_row_out, n_oe_out, row_ready_out, addr_out, latch_out, frame_done_out,
                     phy_start_out, addr_error_out},
              {24'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, then idle with enable low.
        repeat (2) @(posedge clk);
        #1 check_reset_values("reset_values");
        n_reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_outputs", {n_oe_out, row_ready_out, addr_out, latch_out, frame_done_out,
                                   phy_start_out, addr_error_out},
                  {1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        end

        // Full frame, PHY done 50 cycles after start.
        @(posedge clk); #1;
        enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send_row(rgb_row_t'(32'h00A5_0000 + i * 32'h111), 4'(i), 1'b0);
        end
        row_valid = 1'b0;
        wait_latches(16);
        check("frame_count", frame_cnt, 1);
        enable = 1'b0;
        repeat (10) @(posedge clk);

        // Slow PHY: lit window set by fetch+shift time.
        do_reset();
        phy_delay = 500;
        long_mode = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_row(rgb_row_t'(32'h0030_0000 + i), 4'(i), 1'b0);
        end
        row_valid = 1'b0;
        wait_latches(4);
        long_mode = 1'b0;
        enable = 1'b0;
        repeat (10) @(posedge clk);

        // row_valid toggling every cycle.
        do_reset();
        enable = 1'b1;
        toggle_mode = 1'b1;
        send_row(24'h123456, 4'd0, 1'b0);
        send_row(24'hABCDEF, 4'd1, 1'b0);
        send_row(24'h0F0F0F, 4'd2, 1'b0);
        send_row(24'hF0F0F0, 4'd3, 1'b0);
        toggle_mode = 1'b0;
        row_valid = 1'b0;
        wait_latches(4);
        check("start_count", start_cnt, 4);
        enable = 1'b0;
        repeat (10) @(posedge clk);

        // Address sequence 0,1,2,5,6: error only at 5 when the checker is built in.
        do_reset();
        enable = 1'b1;
        send_row(24'h000100, 4'd0, 1'b0);
        send_row(24'h000101, 4'd1, 1'b0);
        send_row(24'h000102, 4'd2, 1'b0);
        send_row(24'h000105, 4'd5, CHK_EN);
        send_row(24'h000106, 4'd6, 1'b0);
        row_valid = 1'b0;
        wait_latches(5);
        enable = 1'b0;
        repeat (10) @(posedge clk);

        // Drop enable during WAIT_DONE: row completes, then IDLE.
        do_reset();
        enable = 1'b1;
        send_row(24'h777777, 4'd0, 1'b0);
        row_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 enable = 1'b0;
        wait_latches(1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("idle_after_drop", {n_oe_out, row_ready_out}, {1'b1, 1'b0});

        // Reset asserted during BLANK of the second row.
        do_reset();
        enable = 1'b1;
        send_row(24'h999999, 4'd9, CHK_EN);
        send_row(24'hAAAAAA, 4'd10, 1'b0);
        row_valid = 1'b0;
        begin
            int n = 0;
            while (latch_cnt < 1 && n < 5000) begin @(posedge clk); n++; end
            n = 0;
            #2;
            while (!phy_done && n < 5000) begin @(posedge clk); #2; n++; end
            n = 0;
            while (!n_oe_out && n < 5000) begin @(posedge clk); #2; n++; end
            if (n >= 5000) fail_now("blank_wait_timeout");
        end
        repeat (3) @(posedge clk);
        #1;
        check("in_blank", {n_oe_out, addr_out}, {1'b1, 4'd9});
        n_reset = 1'b0;
        #1;
        check_reset_values("async_reset_values");
        exp_row_q.delete();
        exp_latch_q.delete();
        exp_err_q.delete();
        repeat (3) @(posedge clk);
        #1 check_reset_values("held_reset_values");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_display_row_sequencer.md
# led_display_row_sequencer

Row scheduler between `led_display_pattern_gen` and the display driver PHY. It pulls one `rgb_row_t` per scan row over a valid/ready handshake and hands it to the PHY for shifting. It then sequences blanking, latch and row-address update, and holds each row lit for a programmed dwell time. It also checks the incoming row-address sequence and flags frame boundaries.

## Interface
Parameters:
- `SYS_CLK_FREQ`, default 100_000_000: system clock in Hz, informational only.
- `ROW_DWELL_CYCLES`, default 2000: minimum number of cycles each row is lit (`n_oe_out` low). Must be ≥ 1.
- `BLANK_CYCLES`, default 16: number of cycles `n_oe_out` is high before the latch. Must be ≥ 1.

Ports:
- `clk_in`  in  1  system clock.
- `n_reset_in`  in  1  reset, asynchronous, active-low.
- `enable_in`  in  1  run request.
- `row_in`  in  `GL_RGB_ROW_W`  row data from the pattern generator.
- `row_valid_in`  in  1  `row_in` is valid.
- `row_ready_out`  out  1  sequencer can accept a row.
- `row_address_in`  in  4  scan address of `row_in`.
- `phy_row_out`  out  `GL_RGB_ROW_W`  captured row, presented to the PHY.
- `phy_start_out`  out  1  one-cycle pulse that starts a PHY shift.
- `phy_done_in`  in  1  one-cycle pulse: PHY shift complete.
- `latch_out`  out  1  panel latch strobe.
- `n_oe_out`  out  1  panel output enable, active-low.
- `addr_out`  out  4  panel row address.
- `frame_done_out`  out  1  one-cycle pulse when row 15 is latched.
- `addr_error_out`  out  1  one-cycle pulse on a row-address sequence mismatch.

## Operation
States: IDLE, FETCH, SHIFT, WAIT_DONE, WAIT_DWELL, BLANK, LATCH, UNBLANK.

- **IDLE:** `n_oe_out`=1. Go to FETCH when `enable_in`=1.
- **FETCH:** `row_ready_out`=1.
  - If `enable_in`=0: go to IDLE. This path is taken only from FETCH; a row already in flight completes first.
  - On `row_valid_in`&&`row_ready_out`: capture `row_in` into `phy_row_out` and `row_address_in` into a pending-address register, then go to SHIFT.
- **SHIFT:** `phy_start_out`=1 for one cycle, then go to WAIT_DONE.
- **WAIT_DONE:** wait for `phy_done_in`, then go to WAIT_DWELL. A `phy_done_in` pulse in any other state is ignored.
- **WAIT_DWELL:** wait until the dwell counter reaches 0, then load the counter with `BLANK_CYCLES` and go to BLANK.
- **BLANK:** `n_oe_out`=1. Decrement the counter; go to LATCH when it reaches 0.
- **LATCH:** `latch_out`=1 and `n_oe_out`=1. `addr_out` takes the pending address. Pulse `frame_done_out` if the pending address is 15. Go to UNBLANK.
- **UNBLANK:** `n_oe_out`=0. Load the dwell counter with `ROW_DWELL_CYCLES`, then go to FETCH.
- **Lit period:** `n_oe_out` stays 0 from UNBLANK through FETCH, SHIFT, WAIT_DONE and WAIT_DWELL. The lit time is therefore max(`ROW_DWELL_CYCLES`, fetch+shift time).
- **Dwell counter:** decrements every cycle while nonzero and saturates at 0. After reset it is 0, so the first row does not wait for dwell.
- **Counter width:** `$clog2(max(ROW_DWELL_CYCLES, BLANK_CYCLES)+1)`.

## Timing
- **Reset values:** state=IDLE, `row_ready_out`=0, `phy_row_out`=0, `phy_start_out`=0, `latch_out`=0, `n_oe_out`=1, `addr_out`=0, `frame_done_out`=0, `addr_error_out`=0, expected address=0, dwell counter=0.
- **Reset mid-operation:** asynchronous return to all reset values in the same cycle; the in-flight row is discarded.
- **Registered outputs:** all outputs are registered. `row_ready_out` is high in the FETCH cycles only.
- **Handshake:**
  - Accept at edge T → `phy_start_out` high for cycle T+1 only. `phy_row_out` is valid from T+1 and is held until the next accept.
  - `row_ready_out` drops the cycle after an accept. At most one row is accepted per row period.
- **Done to blank:** `phy_done_in` at T with the dwell counter already 0 → WAIT_DWELL at T+1, BLANK at T+2.
- **Blank window:** `n_oe_out` is high for exactly `BLANK_CYCLES`+1 cycles. `latch_out` is high in the last of them, coincident with the `addr_out` change.
- **`addr_error_out`:** asserted the cycle after an accept.

## Configuration
- `LED_DISPLAY_ROW_SEQ_ADDR_CHECK_EN` defined:
  - A 4-bit expected-address counter increments on each accept and wraps 15→0.
  - On a mismatch, `addr_error_out` pulses and the counter resyncs to `row_address_in`+1 (mod 16).
- Undefined: no checker logic; `addr_error_out` is tied to 0. `addr_out` still follows the accepted `row_address_in`.

## Structure
- **Add to `led_display_package`:**
  - `GL_NUM_ROW_ADDR`=16 and `GL_ROW_ADDR_W`=4.
  - `typedef enum logic [2:0] row_seq_state_t` holding the eight states.
- **Existing package items used:** `rgb_row_t`, `GL_RGB_ROW_W`.
- **Sub-module:** `led_display_row_timer`, a loadable saturating down-counter with a zero flag. It is shared by the dwell and blank phases.

## Test plan
- Reset with `enable_in`=0 → `n_oe_out`=1, `row_ready_out`=0, `addr_out`=0, and all pulses 0 for 100 cycles.
- `enable_in`=1, rows 0..15 presented continuously, PHY done 50 cycles after start, `ROW_DWELL_CYCLES`=200, `BLANK_CYCLES`=16 → 16 latches with `addr_out` 0..15, exactly one `frame_done_out` (at address 15), every blank window 17 cycles, and every lit window after the first ≥ 200 cycles.
- PHY done 500 cycles after start with dwell 200 → lit window = fetch+shift time (> 200), and BLANK starts 2 cycles after `phy_done_in`.
- With the macro defined, feed addresses 0,1,2,5,6 → one `addr_error_out` at the accept of 5 and none at 6. Macro undefined → no errors.
- `row_valid_in` toggled every cycle → each row accepted once, `phy_start_out` exactly one cycle per accept, `phy_row_out` matches the accepted data.
- Drop `enable_in` during WAIT_DONE → the current row completes through LATCH, then IDLE with `n_oe_out`=1. Assert `n_reset_in` low during BLANK → outputs reach reset values immediately.
